// File: rtl/calc_pkg.sv
// calc_pkg: shared FSM state type and BCD/datapath constants for the calculator blocks.
package calc_pkg;
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
    localparam int BCD_DIGIT_W   = 4;
    localparam int BCD_MAX_DIGIT = 9;
    localparam int CALC_W        = 16;
endpackage

// File: rtl/bcd_mac10.sv
// bcd_mac10: combinational acc*10+digit using shift-add only, and a flag for a digit above 9.
module bcd_mac10 import calc_pkg::*; #(
    parameter int W = CALC_W
) (
    input  logic [W-1:0]           acc_i,
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [W-1:0]           res_o,
    output logic                   bad_o
);
    assign res_o = (acc_i << 3) + (acc_i << 1) + W'(digit_i);
    assign bad_o = digit_i > BCD_DIGIT_W'(BCD_MAX_DIGIT);
endmodule

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential 4-digit BCD to binary converter, one digit per clock, valid/ready on both sides.
// Optional signed result via BCD_SIGN_EN (adds in_neg, two's-complement output).
module bcd_to_bin_seq import calc_pkg::*; #(
    parameter int NUM_DIGITS = 4,
    parameter int OUT_W      = CALC_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BCD_DIGIT_W-1:0] thousands,
    input  logic [BCD_DIGIT_W-1:0] hundreds,
    input  logic [BCD_DIGIT_W-1:0] tens,
    input  logic [BCD_DIGIT_W-1:0] ones,
`ifdef BCD_SIGN_EN
    input  logic                   in_neg,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_data,
    output logic                   out_err
);
    localparam int DW    = NUM_DIGITS * BCD_DIGIT_W;
    localparam int CNT_W = $clog2(NUM_DIGITS);

    state_t               state_q, state_d;
    logic [OUT_W-1:0]     acc_q, acc_d, mac_res;
    logic [DW-1:0]        dig_q, dig_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_q, err_d, mac_bad, accept, last;
`ifdef BCD_SIGN_EN
    logic                 neg_q, neg_d;
`endif

    assign accept = in_valid && in_ready;
    assign last   = cnt_q == CNT_W'(NUM_DIGITS - 1);

    // digits are shifted left each step so the current MSD always sits on top
    bcd_mac10 #(.W(OUT_W)) u_mac (
        .acc_i   (acc_q),
        .digit_i (dig_q[DW-1 -: BCD_DIGIT_W]),
        .res_o   (mac_res),
        .bad_o   (mac_bad)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)    state_d = CONV;
            CONV:    if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        dig_d = dig_q;
        cnt_d = cnt_q;
        err_d = err_q;
`ifdef BCD_SIGN_EN
        neg_d = neg_q;
`endif
        if (accept) begin
            acc_d = '0;
            dig_d = {thousands, hundreds, tens, ones};
            cnt_d = '0;
            err_d = 1'b0;
`ifdef BCD_SIGN_EN
            neg_d = in_neg;
`endif
        end else if (state_q == CONV) begin
            acc_d = mac_res;
            dig_d = dig_q << BCD_DIGIT_W;
            cnt_d = cnt_q + CNT_W'(1);
            err_d = err_q | mac_bad;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
            dig_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
`ifdef BCD_SIGN_EN
            neg_q <= 1'b0;
`endif
        end else begin
            acc_q <= acc_d;
            dig_q <= dig_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
`ifdef BCD_SIGN_EN
            neg_q <= neg_d;
`endif
        end
    end

    always_comb begin
        in_ready  = state_q == IDLE;
        out_valid = state_q == DONE;
        out_err   = out_valid && err_q;
`ifdef BCD_SIGN_EN
        out_data  = (out_valid && !err_q) ? (neg_q ? ~acc_q + OUT_W'(1) : acc_q) : '0;
`else
        out_data  = (out_valid && !err_q) ? acc_q : '0;
`endif
    end
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq: directed self-checking bench for bcd_to_bin_seq (define BCD_SIGN_EN to cover the signed path).
module tb_bcd_to_bin_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [3:0]  thousands = '0, hundreds = '0, tens = '0, ones = '0;
    logic        in_ready, out_valid, out_err;
    logic [15:0] out_data;
`ifdef BCD_SIGN_EN
    logic        in_neg = 1'b0;
`endif
    int checks = 0;
    int failures = 0;

    bcd_to_bin_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .thousands (thousands),
        .hundreds  (hundreds),
        .tens      (tens),
        .ones      (ones),
`ifdef BCD_SIGN_EN
        .in_neg    (in_neg),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_digits(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        thousands = a;
        hundreds  = b;
        tens      = c;
        ones      = d;
    endtask

    task automatic present(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        set_digits(a, b, c, d);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_timeout"}, {15'd0, out_valid}, 16'd1);
    endtask

    task automatic convert(input string tag, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                           input logic [3:0] d, input logic [15:0] exp_data, input logic exp_err);
        present(a, b, c, d);
        wait_valid(tag);
        chk({tag, "_data"}, out_data, exp_data);
        chk({tag, "_err"}, {15'd0, out_err}, {15'd0, exp_err});
        out_ready = 1'b1;
        step();
    endtask

    initial begin
        step();
        step();
        chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
        chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_out_data", out_data, 16'd0);
        chk("rst_out_err", {15'd0, out_err}, 16'd0);
        rst_n = 1'b1;
        step();

        // latency: valid on the 4th edge after the accepting edge
        present(4'd9, 4'd8, 4'd0, 4'd1);
        chk("t1_busy_ready", {15'd0, in_ready}, 16'd0);
        for (int i = 1; i <= 3; i++) begin
            chk("t1_early_valid", {15'd0, out_valid}, 16'd0);
            step();
        end
        chk("t1_early_valid4", {15'd0, out_valid}, 16'd0);
        step();
        chk("t1_valid", {15'd0, out_valid}, 16'd1);
        chk("t1_data", out_data, 16'h2649);
        chk("t1_err", {15'd0, out_err}, 16'd0);
        step();
        chk("t1_ready_back", {15'd0, in_ready}, 16'd1);
        chk("t1_valid_drop", {15'd0, out_valid}, 16'd0);

        convert("t2_zero", 4'd0, 4'd0, 4'd0, 4'd0, 16'h0000, 1'b0);
        convert("t2_max", 4'd9, 4'd9, 4'd9, 4'd9, 16'h270F, 1'b0);
        convert("t3_bad", 4'd1, 4'hA, 4'd3, 4'd4, 16'h0000, 1'b1);
        convert("t3_after", 4'd0, 4'd0, 4'd4, 4'd2, 16'h002A, 1'b0);
        convert("t3_badones", 4'd0, 4'd0, 4'd0, 4'hF, 16'h0000, 1'b1);

        // backpressure with a competing input held valid
        out_ready = 1'b0;
        present(4'd1, 4'd2, 4'd3, 4'd4);
        wait_valid("t4");
        set_digits(4'd7, 4'd7, 4'd7, 4'd7);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("t4_hold_valid", {15'd0, out_valid}, 16'd1);
            chk("t4_hold_data", out_data, 16'h04D2);
            chk("t4_hold_ready", {15'd0, in_ready}, 16'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("t4_idle_ready", {15'd0, in_ready}, 16'd1);
        step();
        in_valid = 1'b0;
        wait_valid("t4_second");
        chk("t4_second_data", out_data, 16'h1E61);
        step();

        // reset mid-conversion
        present(4'd5, 4'd5, 4'd5, 4'd5);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t5_valid", {15'd0, out_valid}, 16'd0);
        chk("t5_data", out_data, 16'd0);
        chk("t5_ready", {15'd0, in_ready}, 16'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t5_no_partial", {15'd0, out_valid}, 16'd0);
        end
        convert("t5_after", 4'd0, 4'd0, 4'd1, 4'd0, 16'h000A, 1'b0);

`ifdef BCD_SIGN_EN
        in_neg = 1'b1;
        convert("t6_neg", 4'd9, 4'd8, 4'd0, 4'd1, 16'hD9B7, 1'b0);
        convert("t6_negzero", 4'd0, 4'd0, 4'd0, 4'd0, 16'h0000, 1'b0);
        convert("t6_negerr", 4'd1, 4'hB, 4'd0, 4'd0, 16'h0000, 1'b1);
        in_neg = 1'b0;
        convert("t6_pos", 4'd9, 4'd8, 4'd0, 4'd1, 16'h2649, 1'b0);
`else
        convert("t6_unsigned", 4'd9, 4'd8, 4'd0, 4'd1, 16'h2649, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
Sequential BCD-to-binary converter; the inverse of the calculator's BCD display path.
- Takes four BCD digits (thousands, hundreds, tens, ones) from keypad/entry logic.
- Produces the 16-bit binary operand consumed by the ALU.
- Uses iterative multiply-by-10 accumulation, one digit per clock.
- Valid/ready handshakes on both sides.

Parameters:
- NUM_DIGITS, 4, number of BCD digits processed per conversion (fixed at 4 for this release).
- OUT_W, 16, binary result width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  digit set presented.
- in_ready  output  1  converter idle and able to accept.
- thousands  input  4  BCD digit, weight 1000.
- hundreds  input  4  BCD digit, weight 100.
- tens  input  4  BCD digit, weight 10.
- ones  input  4  BCD digit, weight 1.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_data  output  16  binary result.
- out_err  output  1  at least one input digit > 9.
- in_neg  input  1  (BCD_SIGN_EN only) negate result.

Behaviour:
- Reset: rst_n sampled low at a rising edge gives:
  - state=IDLE, in_ready=1, out_valid=0, out_data=16'd0, out_err=0.
  - Internal accumulator, digit register and count cleared.
  - Reset overrides everything, including an in-flight conversion; no partial result is emitted.
- Clock/reset rule: one clock, no asynchronous paths.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch all four digits (and in_neg), clear acc, cnt=0, go to CONV.
  - CONV: in_ready=0. Each edge computes acc <= (acc<<3)+(acc<<1)+digit[cnt], MSD first (thousands, hundreds, tens, ones), then cnt++. After the ones digit (4th CONV edge) go to DONE. No multiplier is used; shift-add only.
  - DONE: out_valid=1; out_data and out_err stable. On out_ready, go to IDLE with out_valid<=0.
- Latency: out_valid rises on the 4th rising edge after the accepting edge. With out_ready held high, throughput is one conversion per 6 cycles.
- Handshakes:
  - in_ready is deasserted in CONV and DONE, so no input is accepted during backpressure.
  - out_data/out_err are held unchanged while out_valid=1 and out_ready=0.
  - No IDLE bypass: a new input is accepted only once state is IDLE again, at the earliest the cycle after the out_ready handshake.
- Error:
  - out_err is set when any latched digit > 4'd9; detected during CONV.
  - When out_err=1, out_data is forced to 16'd0.
- Width: acc is 16 bits; the maximum value 9999 = 16'h270F, so no overflow is possible.
- Input digit values are don't-care while in_valid=0.

Optional Feature:
- Macro: BCD_SIGN_EN
- Defined:
  - in_neg port exists and is latched on accept.
  - In DONE, out_data = in_neg ? (~acc + 1) : acc, giving a 16-bit two's complement result.
  - Negative zero gives 16'd0.
  - out_err still forces 0 regardless of sign.
- Undefined: no in_neg port; result is always unsigned.

Decomposition:
- Shared package calc_pkg holds:
  - State enum {IDLE, CONV, DONE}.
  - Constants BCD_DIGIT_W=4, BCD_MAX_DIGIT=9, CALC_W=16.
- One natural sub-module, bcd_mac10: combinational acc*10+digit using shift-add, plus a digit>9 flag. It is instantiated once inside the FSM datapath.

Test Plan:
1. Digits 9,8,0,1, in_valid one cycle, out_ready=1 → out_valid on the 4th edge after accept; out_data=16'h2649 (9801); out_err=0; in_ready returns to 1 the cycle after the handshake.
2. Digits 0,0,0,0 → out_data=16'h0000. Digits 9,9,9,9 → out_data=16'h270F, out_err=0.
3. Digits 1,A,3,4 → out_err=1, out_data=16'h0000; the following valid input 0,0,4,2 → 16'h002A with out_err=0 (error does not stick).
4. Backpressure, digits 1,2,3,4:
   - Hold out_ready=0 for 10 cycles → out_valid stays 1, out_data=16'h04D2 stable, in_ready=0.
   - A second in_valid presented meanwhile is ignored until IDLE.
5. Reset: assert rst_n=0 on the 2nd CONV cycle of 5,5,5,5 → next edge gives IDLE, out_valid=0, out_data=0, in_ready=1. A subsequent 0,0,1,0 gives 16'h000A.
6. BCD_SIGN_EN defined:
   - 9,8,0,1 with in_neg=1 → 16'hD9B7.
   - 0,0,0,0 with in_neg=1 → 16'h0000.
   - With the macro undefined, 9,8,0,1 → 16'h2649.
